// File: rtl/register_file_32x32_pkg.sv
// Shared sizing constants and types for the 32x32 register file.
package register_file_32x32_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [NUM_REGS-1:0]   onehot_t;

  localparam addr_t ZERO_REG = '0;

  function automatic logic is_zero_reg(input addr_t addr);
    return addr == ZERO_REG;
  endfunction

endpackage

// File: rtl/register_file_32x32_if.sv
// Write-back and operand-read bus between the datapath and the register file.
interface register_file_32x32_if;
  import register_file_32x32_pkg::*;

  logic  we;
  addr_t write_addr;
  word_t write_data;
  addr_t read_addr1;
  addr_t read_addr2;
  word_t read_data1;
  word_t read_data2;

  modport master (
    output we, write_addr, write_data, read_addr1, read_addr2,
    input  read_data1, read_data2
  );

  modport slave (
    input  we, write_addr, write_data, read_addr1, read_addr2,
    output read_data1, read_data2
  );

endinterface

// File: rtl/register_file_32x32_storage.sv
// Write-enable decoder and the 32-bit parallel-load register cell used for storage.
module decoder_5to32
  import register_file_32x32_pkg::*;
(
  input  addr_t   addr,
  input  logic    en,
  output onehot_t onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
    // Register 0 has no storage, so it never gets a write strobe.
    onehot[ZERO_REG] = 1'b0;
  end

endmodule

module reg_cell_32
  import register_file_32x32_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  logic  rst,
  input  word_t d,
  output word_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end

endmodule

// File: rtl/register_file_32x32.sv
// 32x32 register file: one synchronous write port, two combinational read ports, r0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module register_file_32x32
  import register_file_32x32_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  register_file_32x32_if.slave  bus
);

  onehot_t wr_sel;
  word_t   regs [NUM_REGS];

  decoder_5to32 u_dec (
    .addr   (bus.write_addr),
    .en     (bus.we),
    .onehot (wr_sel)
  );

  assign regs[ZERO_REG] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    reg_cell_32 u_cell (
      .clk (clk),
      .we  (wr_sel[i]),
      .rst (rst),
      .d   (bus.write_data),
      .q   (regs[i])
    );
  end

`ifdef REGFILE_BYPASS_EN
  logic bypass_ok;

  // Stored state is already zero during reset, so gating the bypass is enough.
  assign bypass_ok = !rst && bus.we && !is_zero_reg(bus.write_addr);

  assign bus.read_data1 = (bypass_ok && bus.read_addr1 == bus.write_addr) ?
                          bus.write_data : regs[bus.read_addr1];
  assign bus.read_data2 = (bypass_ok && bus.read_addr2 == bus.write_addr) ?
                          bus.write_data : regs[bus.read_addr2];
`else
  assign bus.read_data1 = regs[bus.read_addr1];
  assign bus.read_data2 = regs[bus.read_addr2];
`endif

endmodule

// File: tb/tb_register_file_32x32.sv
// Directed self-checking bench for register_file_32x32 (honours REGFILE_BYPASS_EN).
module tb_register_file_32x32;
  import register_file_32x32_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  register_file_32x32_if bus ();

  register_file_32x32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input addr_t a1, input addr_t a2);
    bus.read_addr1 = a1;
    bus.read_addr2 = a2;
    #1;
  endtask

  task automatic wr(input addr_t a, input word_t d);
    @(negedge clk);
    bus.we         = 1'b1;
    bus.write_addr = a;
    bus.write_data = d;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  initial begin
    word_t exp_same;
    bus.we         = 1'b0;
    bus.write_addr = '0;
    bus.write_data = '0;
    bus.read_addr1 = '0;
    bus.read_addr2 = '0;

    // Async reset pulse in the clock-low phase, no edge in between
    @(negedge clk);
    bus.read_addr1 = 5'd5;
    bus.read_addr2 = 5'd17;
    #1 rst = 1'b1;
    #1;
    check("rst_async_rd1", bus.read_data1, 32'h0);
    check("rst_async_rd2", bus.read_data2, 32'h0);
    #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd(addr_t'(i), addr_t'(31 - i));
      check("rst_sweep_rd1", bus.read_data1, 32'h0);
      check("rst_sweep_rd2", bus.read_data2, 32'h0);
    end

    // Basic write/read
    wr(5'd5,  32'hDEADBEEF);
    wr(5'd31, 32'h12345678);
    rd(5'd5, 5'd31);
    check("wr_r5",  bus.read_data1, 32'hDEADBEEF);
    check("wr_r31", bus.read_data2, 32'h12345678);
    rd(5'd6, 5'd5);
    check("r6_untouched", bus.read_data1, 32'h0);
    check("r5_port2",     bus.read_data2, 32'hDEADBEEF);

    // Writes to r0 are discarded
    wr(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd0);
    check("r0_rd1", bus.read_data1, 32'h0);
    check("r0_rd2", bus.read_data2, 32'h0);
    rd(5'd5, 5'd31);
    check("r0_wr_r5_hold",  bus.read_data1, 32'hDEADBEEF);
    check("r0_wr_r31_hold", bus.read_data2, 32'h12345678);

    // we=0 holds for three edges, then one enabled edge
    @(negedge clk);
    bus.we         = 1'b0;
    bus.write_addr = 5'd7;
    bus.write_data = 32'hAAAAAAAA;
    repeat (3) @(posedge clk);
    #1;
    rd(5'd7, 5'd5);
    check("we0_r7_hold", bus.read_data1, 32'h0);
    check("we0_r5_hold", bus.read_data2, 32'hDEADBEEF);
    wr(5'd7, 32'hAAAAAAAA);
    rd(5'd7, 5'd7);
    check("we1_r7_rd1", bus.read_data1, 32'hAAAAAAAA);
    check("we1_r7_rd2", bus.read_data2, 32'hAAAAAAAA);

    // Same-cycle read/write on r9
    wr(5'd9, 32'h11111111);
    @(negedge clk);
    bus.we         = 1'b1;
    bus.write_addr = 5'd9;
    bus.write_data = 32'h22222222;
    bus.read_addr1 = 5'd9;
    bus.read_addr2 = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h22222222;
`else
    exp_same = 32'h11111111;
`endif
    check("r9_same_cycle",   bus.read_data1, exp_same);
    check("r7_no_bypass",    bus.read_data2, 32'hAAAAAAAA);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    rd(5'd9, 5'd9);
    check("r9_after_edge", bus.read_data1, 32'h22222222);

    // Fill r1..r31 with their index
    for (int i = 1; i < 32; i++) wr(addr_t'(i), word_t'(i));
    rd(5'd3, 5'd31);
    check("fill_r3",  bus.read_data1, 32'd3);
    check("fill_r31", bus.read_data2, 32'd31);
    rd(5'd16, 5'd1);
    check("fill_r16", bus.read_data1, 32'd16);
    check("fill_r1",  bus.read_data2, 32'd1);

    // Reset asserted during a pending write to r3
    @(negedge clk);
    bus.we         = 1'b1;
    bus.write_addr = 5'd3;
    bus.write_data = 32'h55555555;
    bus.read_addr1 = 5'd3;
    bus.read_addr2 = 5'd30;
    #1 rst = 1'b1;
    #1;
    check("midrst_r3_rd1",  bus.read_data1, 32'h0);
    check("midrst_r30_rd2", bus.read_data2, 32'h0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      rd(addr_t'(i), addr_t'(31 - i));
      check("midrst_sweep_rd1", bus.read_data1, 32'h0);
      check("midrst_sweep_rd2", bus.read_data2, 32'h0);
    end
    @(negedge clk);
    bus.we = 1'b0;
    rst    = 1'b0;
    @(posedge clk);
    #1;
    rd(5'd3, 5'd1);
    check("postrst_r3_lost", bus.read_data1, 32'h0);
    check("postrst_r1",      bus.read_data2, 32'h0);
    wr(5'd3, 32'h55555555);
    rd(5'd3, 5'd2);
    check("postrst_r3_fresh", bus.read_data1, 32'h55555555);
    check("postrst_r2",       bus.read_data2, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/register_file_32x32.md
Name: register_file_32x32

Overview:
- 32-entry × 32-bit register file: one synchronous write port, two asynchronous (combinational) read ports.
- Sits directly downstream of the 32-bit parallel-load register cell. It instantiates 31 of those cells plus address decode and read muxing.
- Register 0 reads as constant zero.
- Feeds operand A/B to the datapath and accepts the write-back value.

Parameters:
- DATA_WIDTH, 32, width of each register and data port.
- ADDR_WIDTH, 5, register address width.
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset; clears all registers.
- we  input  1  write enable for write port.
- write_addr  input  ADDR_WIDTH  destination register index.
- write_data  input  DATA_WIDTH  value to write.
- read_addr1  input  ADDR_WIDTH  read port 1 index.
- read_addr2  input  ADDR_WIDTH  read port 2 index.
- read_data1  output  DATA_WIDTH  contents of register read_addr1.
- read_data2  output  DATA_WIDTH  contents of register read_addr2.

Behaviour:
- Reset:
  - rst high → all registers 0 immediately, independent of clk.
  - read_data1/2 = 0 while rst is high and after it deasserts, until a write lands.
  - rst asserted mid-write cycle: reset wins, and that write is lost.
- Write:
  - On rising clk with we=1 and rst=0, register[write_addr] ← write_data.
  - Exactly one register updates per edge; all others hold.
  - we=0 → no register changes.
- Register 0:
  - Writes to address 0 are discarded; no flop is instantiated for it.
  - Read of address 0 always returns 0.
- Read:
  - Purely combinational from stored state, no clock latency.
  - Both ports are independent and may address the same register simultaneously.
- Write latency: a written value is visible on a read port from the cycle after the write edge (subject to the Optional Feature).
- Unknown/X on write_addr with we=1 is a protocol violation; no required behaviour.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If we=1, write_addr≠0 and read_addrN==write_addr in the same cycle, read_dataN = write_data combinationally, before the edge.
  - Bypass is suppressed while rst=1 (reads return 0).
- Undefined:
  - Reads in the write cycle return the old stored value.
  - New value appears only after the edge.

Decomposition:
- Shared package/include: DATA_WIDTH, ADDR_WIDTH, NUM_REGS constants and the ZERO_REG index (0).
- One natural sub-module: decoder_5to32 (5-bit address + enable → one-hot 32-bit write-enable vector, bit 0 forced low).
- Storage reuses the team's existing 32-bit parallel register cell (clk, we, rst, D, Q), generated for indices 1..31.
- Read muxes are inline in the top level.

Test Plan:
- Reset: pulse rst between clock edges (async), read addresses 0..31 on both ports → every read 0x00000000, with no clk edge needed.
- Basic write/read: write 0xDEADBEEF to r5, then 0x12345678 to r31 → next cycle read1=r5 gives 0xDEADBEEF, read2=r31 gives 0x12345678; r6 still 0.
- Zero register: we=1, addr 0, data 0xFFFFFFFF → read of r0 stays 0x00000000 on both ports.
- we=0 hold: present addr 7, data 0xAAAAAAAA, we=0 for 3 edges → r7 stays 0; then we=1 one edge → r7 = 0xAAAAAAAA.
- Same-cycle read/write on r9 (old 0x11111111, new 0x22222222):
  - Without REGFILE_BYPASS_EN: read gives 0x11111111 before the edge, 0x22222222 after.
  - With the macro: read gives 0x22222222 before the edge.
- Reset mid-operation: fill r1..r31 with index values, assert rst asynchronously with we=1, addr 3, data 0x55555555 → all reads 0; after deassert, r3 still 0 until a fresh write.
